// File: rtl/pbit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pbit_pkg
//  Purpose  : Shared constants for the p-bit network: default input width,
//             LFSR feedback taps, node FSM encoding and the tanh threshold LUT.
//  Revision : 1.0 - initial release
// ============================================================================
package pbit_pkg;

    localparam int          c_IN_PRECISION_DEF = 6;
    localparam int          c_FRAC_BITS_DEF    = 2;
    localparam logic [15:0] c_LFSR_SEED_DEF    = 16'hACE1;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from state bits 15, 13, 12, 10
    localparam logic [15:0] c_LFSR_TAPS        = 16'hB400;

    // Node FSM encoding
    localparam logic [0:0]  c_ST_IDLE          = 1'b0;
    localparam logic [0:0]  c_ST_EVAL          = 1'b1;

    // T(I) = round(127 * tanh(I * 2^-frac)).  Magnitudes are tabulated at
    // quarter-unit steps of the real argument; other fractional widths are
    // resampled onto that grid.  Beyond 3.25 the rounded value sits at 127.
    function automatic logic signed [7:0] tanh_lut(input int i_val, input int frac);
        int                 mag;
        int                 idx;
        logic signed [7:0]  m;
        mag = (i_val < 0) ? -i_val : i_val;
        if (frac <= 2) begin
            idx = mag << (2 - frac);
        end else begin
            idx = (mag + (1 << (frac - 3))) >> (frac - 2);
        end
        case (idx)
            0:       m = 8'sd0;
            1:       m = 8'sd31;
            2:       m = 8'sd59;
            3:       m = 8'sd81;
            4:       m = 8'sd97;
            5:       m = 8'sd108;
            6:       m = 8'sd115;
            7:       m = 8'sd120;
            8:       m = 8'sd122;
            9:       m = 8'sd124;
            10:      m = 8'sd125;
            11:      m = 8'sd126;
            12:      m = 8'sd126;
            default: m = 8'sd127;
        endcase
        return (i_val < 0) ? -m : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pbit_node_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Purpose  : 16-bit Fibonacci LFSR supplying the random sample for one node.
//             Advances only on request; a seed load overrides the advance and
//             an all-zero seed is replaced by 0x0001 to avoid lock-up.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr16
    import pbit_pkg::*;
#(
    parameter logic [15:0] SEED = c_LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next state: load wins over advance, otherwise hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (adv) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & c_LFSR_TAPS)};
        end
    end

    // State register, returns to SEED on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/pbit_node.sv
`default_nettype none
// ============================================================================
//  Module   : pbit_node
//  Purpose  : Stochastic p-bit. On an accepted update the signed input current
//             is captured with an 8-bit LFSR sample; one cycle later the new
//             p-bit is (tanh threshold of I) > sample, with a one-cycle valid.
//  Revision : 1.0 - initial release
// ============================================================================
module pbit_node
    import pbit_pkg::*;
#(
    parameter int          IN_PRECISION = c_IN_PRECISION_DEF,
    parameter int          FRAC_BITS    = c_FRAC_BITS_DEF,
    parameter logic [15:0] SEED         = c_LFSR_SEED_DEF,
    parameter logic        P_RESET      = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [IN_PRECISION-1:0] i_in,
    input  logic                           update_req,
    input  logic                           freeze,
    input  logic                           seed_load,
    input  logic [15:0]                    seed_in,
    output logic                           busy,
    output logic                           p_out,
    output logic                           p_valid
);

    logic [0:0]                     state_q;
    logic [0:0]                     state_d;
    logic signed [IN_PRECISION-1:0] i_cap_q;
    logic signed [7:0]              r_cap_q;
    logic                           p_q;
    logic                           p_valid_q;

    logic                           w_accept;
    logic [15:0]                    w_lfsr;
    logic signed [7:0]              w_thresh;
    logic                           w_unused_lfsr;

    // Random source; the sample taken at accept is the pre-edge state
    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (w_accept),
        .load (seed_load),
        .seed (seed_in),
        .q    (w_lfsr)
    );

    // Only the low byte feeds the comparator
    assign w_unused_lfsr = ^w_lfsr[15:8];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> EVAL on accept, EVAL always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_accept) state_d = c_ST_EVAL;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and the accept strobe (dropped while busy/frozen)
    always_comb begin
        busy     = (state_q == c_ST_EVAL);
        w_accept = update_req && !freeze && (state_q == c_ST_IDLE);
    end

    // Threshold lookup on the captured current
    assign w_thresh = tanh_lut(int'(i_cap_q), FRAC_BITS);

    // Capture on accept, resolve the p-bit and pulse valid on the completing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cap_q   <= '0;
            r_cap_q   <= '0;
            p_q       <= P_RESET;
            p_valid_q <= 1'b0;
        end else begin
            if (w_accept) begin
                i_cap_q <= i_in;
                r_cap_q <= w_lfsr[7:0];
            end
            if (state_q == c_ST_EVAL) begin
                p_q       <= (w_thresh > r_cap_q);
                p_valid_q <= 1'b1;
            end else begin
                p_valid_q <= 1'b0;
            end
        end
    end

    assign p_out   = p_q;
    assign p_valid = p_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pbit_node.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pbit_node
//  Purpose  : Scoreboard bench for pbit_node. Stimulus pushes the expected
//             p-bit per accepted update; a monitor pops on every p_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pbit_node;

    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [5:0] i_in;
    logic              update_req;
    logic              freeze;
    logic              seed_load;
    logic [15:0]       seed_in;
    logic              busy;
    logic              p_out;
    logic              p_valid;

    int                n_vec    = 0;
    int                n_miss   = 0;
    int                ones_cnt = 0;
    logic              exp_q[$];
    logic [15:0]       m_lfsr;

    always #5 clk = ~clk;

    pbit_node #(
        .IN_PRECISION (6),
        .FRAC_BITS    (2),
        .SEED         (SEED),
        .P_RESET      (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_in       (i_in),
        .update_req (update_req),
        .freeze     (freeze),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .busy       (busy),
        .p_out      (p_out),
        .p_valid    (p_valid)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: compare every presented p-bit against the scoreboard head
    always @(posedge clk) begin : mon
        logic e;
        #1;
        if (p_valid === 1'b1) begin
            if (p_out === 1'b1) ones_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected p_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("p_out", {31'd0, p_out}, {31'd0, e});
            end
        end
    end

    // One update from a negedge; hand >= 0 gives a hand-computed result,
    // otherwise the result is T > r with r taken from the LFSR model.
    task automatic do_update(input int iv, input int t, input int hand);
        int                guard;
        logic signed [7:0] r;
        logic              e;
        guard = 0;
        while (busy !== 1'b0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) check("busy timeout", 32'd1, 32'd0);
        r      = m_lfsr[7:0];
        m_lfsr = lfsr_next(m_lfsr);
        e      = (hand >= 0) ? hand[0] : (t > int'(r));
        exp_q.push_back(e);
        i_in       = iv[5:0];
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_seed(input logic [15:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr    = (s == 16'h0000) ? 16'h0001 : s;
    endtask

    initial begin
        int                guard;
        logic signed [7:0] r;
        rst        = 1'b1;
        i_in       = '0;
        update_req = 1'b0;
        freeze     = 1'b0;
        seed_load  = 1'b0;
        seed_in    = '0;
        m_lfsr     = SEED;
        repeat (2) @(negedge clk);
        check("reset busy",    {31'd0, busy},    32'd0);
        check("reset p_valid", {31'd0, p_valid}, 32'd0);
        check("reset p_out",   {31'd0, p_out},   32'd0);
        check("reset lfsr",    {16'd0, dut.w_lfsr}, {16'd0, SEED});
        rst = 1'b0;
        @(negedge clk);

        // I=0: r=0xE1(-31), T=0 -> 1; LFSR steps to 59C3
        do_update(0, 0, 1);
        check("lfsr after first", {16'd0, dut.w_lfsr}, 32'h59C3);
        // I=-32: r=0xC3(-61), T=-127 -> 0
        do_update(-32, -127, 0);
        // Fresh seed 1234: r=0x34, T=127 -> 1
        do_seed(16'h1234);
        do_update(31, 127, 1);

        // Request held for 6 cycles: accepts at alternate edges
        for (int k = 0; k < 3; k++) begin
            r      = m_lfsr[7:0];
            m_lfsr = lfsr_next(m_lfsr);
            exp_q.push_back(127 > int'(r));
        end
        i_in       = 6'sd31;
        update_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("held busy",    {31'd0, busy},    {31'd0, (k % 2 == 0)});
            check("held p_valid", {31'd0, p_valid}, {31'd0, (k % 2 == 1)});
        end
        update_req = 1'b0;
        @(negedge clk);

        // Freeze blocks requests and holds the LFSR
        freeze     = 1'b1;
        update_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("freeze busy",    {31'd0, busy},    32'd0);
            check("freeze p_valid", {31'd0, p_valid}, 32'd0);
        end
        check("freeze lfsr", {16'd0, dut.w_lfsr}, {16'd0, m_lfsr});
        update_req = 1'b0;
        freeze     = 1'b0;

        // Zero seed is replaced by 0001
        do_seed(16'h0000);
        check("zero seed lfsr", {16'd0, dut.w_lfsr}, 32'h0001);

        // Freeze rising mid-update does not cancel it: r=0x01, T=127 -> 1
        r      = m_lfsr[7:0];
        m_lfsr = lfsr_next(m_lfsr);
        exp_q.push_back(1'b1);
        i_in       = 6'sd31;
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
        freeze     = 1'b1;
        @(negedge clk);
        check("inflight busy", {31'd0, busy}, 32'd0);
        freeze = 1'b0;
        @(negedge clk);
        check("p_out before abort", {31'd0, p_out}, 32'd1);

        // Reset between accept and completion aborts the update
        i_in       = 6'sd31;
        update_req = 1'b1;
        @(posedge clk);
        #2;
        rst        = 1'b1;
        update_req = 1'b0;
        #1;
        check("abort busy",    {31'd0, busy},    32'd0);
        check("abort p_out",   {31'd0, p_out},   32'd0);
        check("abort p_valid", {31'd0, p_valid}, 32'd0);
        check("abort lfsr",    {16'd0, dut.w_lfsr}, {16'd0, SEED});
        m_lfsr = SEED;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Statistics: I=4 (T=97) and I=0 (T=0)
        ones_cnt = 0;
        repeat (4096) do_update(4, 97, -1);
        check_range("ones at I=4", ones_cnt, 3482, 3727);
        ones_cnt = 0;
        repeat (4096) do_update(0, 0, -1);
        check_range("ones at I=0", ones_cnt, 1926, 2170);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
